// File: rtl/pipe_delay_pkg.sv
// pipe_delay_pkg: shared constants and helpers for the pipe_delay slice.
//
// Contents:
//   clog2Min1(value) - ceil(log2(value)) clamped to at least 1, so that a
//                      counter sized from it is never zero bits wide.
package pipe_delay_pkg;

  function automatic int clog2Min1(input int value);
    int result;
    result = $clog2(value);
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one elastic register slot of the delay line (valid bit + data).
//
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   flush_i       - synchronous clear of the valid bit
//   up_valid_i    - upstream offers a word
//   up_data_i     - upstream word
//   up_ready_o    - this slot can take a word (empty, or emptying this cycle)
//   dn_valid_o    - this slot holds a word
//   dn_data_o     - word held in this slot
//   dn_ready_i    - downstream takes the held word this cycle
module pipe_stage
  import pipe_delay_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic             move;
  logic             load;

  // A slot that is emptying this cycle can refill in the same cycle; this is
  // what lets bubbles collapse and keeps full-rate streaming.
  assign move       = valid_q && dn_ready_i;
  assign up_ready_o = !valid_q || move;
  assign load       = up_valid_i && up_ready_o;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (move) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data needs no reset: it is only observed while valid_q is set.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= up_data_i;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;

endmodule

// File: rtl/pipe_delay.sv
// pipe_delay: elastic delay line of DEPTH register stages with valid/ready
// handshake, synchronous flush and occupancy count. DEPTH=0 is a pure
// combinational pass-through.
//
// Parameters:
//   WIDTH - data width in bits
//   DEPTH - number of register stages
//   CW    - width of count
// Ports:
//   clk, rst_n           - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    - producer handshake, in_data is the offered word
//   out_valid/out_ready  - consumer handshake, out_data is the last stage word
//   flush                - clear all stages and count at the next edge
//   count                - number of words currently held
module pipe_delay
  import pipe_delay_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CW    = clog2Min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  if (DEPTH == 0) begin : g_bypass

    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready && !flush;
    assign count     = '0;

  end else begin : g_pipe

    // Element k feeds stage k; element DEPTH is the consumer side.
    logic             validChain [DEPTH+1];
    logic [WIDTH-1:0] dataChain  [DEPTH+1];
    logic             readyChain [DEPTH+1];
    logic             accept;
    logic             emit;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Ready ripples combinationally from out_ready back to stage 0.
    assign in_ready          = !flush && readyChain[0];
    assign accept            = in_valid && in_ready;
    assign validChain[0]     = accept;
    assign dataChain[0]      = in_data;
    assign readyChain[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .up_valid_i(validChain[k]),
        .up_data_i (dataChain[k]),
        .up_ready_o(readyChain[k]),
        .dn_valid_o(validChain[k+1]),
        .dn_data_o (dataChain[k+1]),
        .dn_ready_i(readyChain[k+1])
      );
    end

    assign out_valid = validChain[DEPTH];
    assign out_data  = dataChain[DEPTH];
    assign emit      = out_valid && out_ready;

    // Tracks popcount of the stage valids without summing them; an emit in a
    // flush cycle is still a real transfer but the count clears regardless.
    always_comb begin
      count_d = count_q;
      if (flush) begin
        count_d = '0;
      end else if (accept && !emit) begin
        count_d = count_q + CW'(1);
      end else if (emit && !accept) begin
        count_d = count_q - CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign count = count_q;

  end

endmodule

// File: tb/tb_pipe_delay.sv
// tb_pipe_delay: self-checking bench for pipe_delay (DEPTH=3 and DEPTH=0).
module tb_pipe_delay;

  localparam int Width = 8;
  localparam int Depth = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic       flush;
  logic [1:0] count;

  logic       inValid0;
  logic       inReady0;
  logic [7:0] inData0;
  logic       outValid0;
  logic       outReady0;
  logic [7:0] outData0;
  logic       flush0;
  logic [0:0] count0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_delay #(
    .WIDTH(Width),
    .DEPTH(Depth)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_data  (inData),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_data (outData),
    .flush    (flush),
    .count    (count)
  );

  pipe_delay #(
    .WIDTH(Width),
    .DEPTH(0)
  ) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inValid0),
    .in_ready (inReady0),
    .in_data  (inData0),
    .out_valid(outValid0),
    .out_ready(outReady0),
    .out_data (outData0),
    .flush    (flush0),
    .count    (count0)
  );

  typedef struct {
    logic       inValid;
    logic [7:0] inData;
    logic       outReady;
    logic       flush;
    logic       expInReady;
    logic       expOutValid;
    logic [7:0] expOutData;
    logic [1:0] expCount;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         age;
  } entry_t;

  vec_t   vecs[$];
  entry_t model[$];

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic iv, input logic [7:0] d, input logic orr,
                        input logic fl, input logic er, input logic ev,
                        input logic [7:0] ed, input logic [1:0] ec);
    vec_t v;
    v = '{iv, d, orr, fl, er, ev, ed, ec};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] d,
                               input logic orr, input logic fl);
    inValid  = iv;
    inData   = d;
    outReady = orr;
    flush    = fl;
  endtask

  task automatic checkOutput(input string tag, input logic er, input logic ev,
                             input logic [7:0] ed, input logic [1:0] ec);
    checkValue({tag, " in_ready"}, {31'd0, inReady}, {31'd0, er});
    checkValue({tag, " out_valid"}, {31'd0, outValid}, {31'd0, ev});
    if (ev) begin
      checkValue({tag, " out_data"}, {24'd0, outData}, {24'd0, ed});
    end
    checkValue({tag, " count"}, {30'd0, count}, {30'd0, ec});
  endtask

  // One cycle: inputs driven just after the rising edge, outputs checked on
  // the falling edge.
  task automatic stepCycle(input logic iv, input logic [7:0] d, input logic orr,
                           input logic fl);
    applyStimulus(iv, d, orr, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       pending;
    logic [7:0] pendData;
    logic       orr;
    logic       fl;
    logic       expValid;
    logic [7:0] expData;
    logic       expReady;

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    inValid0  = 1'b0;
    inData0   = 8'h00;
    outReady0 = 1'b0;
    flush0    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset out_valid", {31'd0, outValid}, 32'd0);
    checkValue("reset count", {30'd0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkValue("post-reset in_ready", {31'd0, inReady}, 32'd1);

    // Stream, out_ready=1
    addVec(1, 8'h11, 1, 0, 1, 0, 8'h00, 0);
    addVec(1, 8'h22, 1, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'h33, 1, 0, 1, 0, 8'h00, 2);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h11, 3);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h22, 2);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h33, 1);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Backpressure: producer holds A3 until it is taken
    addVec(1, 8'hA0, 0, 0, 1, 0, 8'h00, 0);
    addVec(1, 8'hA1, 0, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'hA2, 0, 0, 1, 0, 8'h00, 2);
    addVec(1, 8'hA3, 0, 0, 0, 1, 8'hA0, 3);
    addVec(1, 8'hA3, 0, 0, 0, 1, 8'hA0, 3);
    addVec(1, 8'hA3, 1, 0, 1, 1, 8'hA0, 3);
    addVec(1, 8'hA4, 1, 0, 1, 1, 8'hA1, 3);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'hA2, 3);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'hA3, 2);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'hA4, 1);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Full pipe, accept and emit together
    addVec(1, 8'h51, 0, 0, 1, 0, 8'h00, 0);
    addVec(1, 8'h52, 0, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'h53, 0, 0, 1, 0, 8'h00, 2);
    addVec(1, 8'h55, 1, 0, 1, 1, 8'h51, 3);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h52, 3);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h53, 2);
    addVec(0, 8'h00, 1, 0, 1, 1, 8'h55, 1);
    addVec(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Flush with count=2 and a word on offer
    addVec(1, 8'h61, 0, 0, 1, 0, 8'h00, 0);
    addVec(1, 8'h62, 0, 0, 1, 0, 8'h00, 1);
    addVec(1, 8'h63, 0, 1, 0, 0, 8'h00, 2);
    addVec(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    addVec(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    addVec(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].inValid, vecs[i].inData, vecs[i].outReady, vecs[i].flush);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].expInReady, vecs[i].expOutValid,
                  vecs[i].expOutData, vecs[i].expCount);
      @(posedge clk);
      #1;
    end

    // Reset mid-stream with two words held, one already at the output
    stepCycle(1'b1, 8'h71, 1'b0, 1'b0);
    stepCycle(1'b0, 8'h00, 1'b0, 1'b0);
    stepCycle(1'b1, 8'h72, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h73, 1'b0, 1'b0);
    checkValue("midstream count", {30'd0, count}, 32'd2);
    checkValue("midstream out_valid", {31'd0, outValid}, 32'd1);
    checkValue("midstream out_data", {24'd0, outData}, 32'h71);
    rst_n = 1'b0;
    #1;
    checkValue("async reset out_valid", {31'd0, outValid}, 32'd0);
    checkValue("async reset count", {30'd0, count}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkValue("release in_ready", {31'd0, inReady}, 32'd1);
    checkValue("release count", {30'd0, count}, 32'd0);
    @(posedge clk);
    #1;

    // DEPTH=0 pass-through
    for (int i = 0; i < 6; i++) begin
      inValid0  = (i != 5);
      inData0   = 8'h3C;
      outReady0 = (i % 2 == 1);
      flush0    = (i == 4);
      @(negedge clk);
      checkValue($sformatf("d0[%0d] out_valid", i), {31'd0, outValid0}, {31'd0, (i != 5)});
      checkValue($sformatf("d0[%0d] out_data", i), {24'd0, outData0}, 32'h3C);
      checkValue($sformatf("d0[%0d] in_ready", i), {31'd0, inReady0},
                 {31'd0, ((i % 2 == 1) && (i != 4))});
      checkValue($sformatf("d0[%0d] count", i), {31'd0, count0}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Random traffic against a queue model: the pipe holds up to Depth words
    // in order, and a word may leave once it has aged Depth-1 edges.
    pending  = 1'b0;
    pendData = 8'h00;
    model.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pending) begin
        pending  = ($urandom_range(0, 3) != 0);
        pendData = 8'($urandom);
      end
      if ((cyc / 50) % 2 == 0) begin
        orr = ($urandom_range(0, 3) != 0);
      end else begin
        orr = ($urandom_range(0, 3) == 0);
      end
      fl = ($urandom_range(0, 29) == 0);
      applyStimulus(pending, pending ? pendData : 8'($urandom), orr, fl);
      @(negedge clk);
      expValid = (model.size() > 0) && (model[0].age >= Depth - 1);
      expData  = expValid ? model[0].data : 8'h00;
      expReady = !fl && ((model.size() < Depth) || (expValid && orr));
      checkOutput($sformatf("rand%0d", cyc), expReady, expValid, expData, 2'(model.size()));
      @(posedge clk);
      if (expValid && orr) begin
        void'(model.pop_front());
      end
      foreach (model[j]) begin
        model[j].age++;
      end
      if (fl) begin
        model.delete();
      end else if (pending && expReady) begin
        model.push_back('{pendData, 0});
        pending = 1'b0;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
